// File: rtl/hist_builder_mp_pkg.sv
// Shared definitions for the multi-pixel histogram builder: default widths,
// binning mode encodings and FSM state encoding.
package hist_builder_mp_pkg;

   localparam int NP_DEF         = 10;
   localparam int NB_DEF         = 4;
   localparam int PIXELS_DEF     = 3;
   localparam int CNT_W_DEF      = 8;
   localparam int FINE_SHIFT_DEF = 2;

   localparam logic MODE_COARSE = 1'b0;
   localparam logic MODE_FINE   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ACQ   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_OUT   = 3'd3,
      ST_CLEAR = 3'd4
   } state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/hist_builder_mp_bin_map.sv
// Timestamp to bin mapping: coarse takes the MSBs of the full range, fine zooms
// into a window starting at fine_base. Also returns the absolute bin start.
module hist_builder_mp_bin_map
   import hist_builder_mp_pkg::*;
#(
   parameter int NP         = NP_DEF,
   parameter int NB         = NB_DEF,
   parameter int FINE_SHIFT = FINE_SHIFT_DEF
) (
   input  logic [NP-1:0] data,
   input  logic          mode,
   input  logic [NP-1:0] fine_base,
   output logic [NB-1:0] bin,
   output logic          in_range,
   output logic [NP-1:0] bin_abs
);

   logic [NP-1:0] diff;
   logic [NP-1:0] zoom;

   always_comb begin
      diff = data - fine_base;
      zoom = diff >> FINE_SHIFT;
      if (mode == MODE_FINE) begin
         bin      = zoom[NB-1:0];
         // data below the base would wrap diff, so it is rejected explicitly
         in_range = (data >= fine_base) && ((zoom >> NB) == '0);
         bin_abs  = fine_base + (NP'(zoom[NB-1:0]) << FINE_SHIFT);
      end else begin
         bin      = data[NP-1 -: NB];
         in_range = 1'b1;
         bin_abs  = {data[NP-1 -: NB], {(NP-NB){1'b0}}};
      end
   end

endmodule

// File: rtl/hist_builder_mp.sv
// Multi-pixel dToF histogram builder: bins timestamps per pixel, tracks each
// pixel's peak online, streams one peak record per pixel, then clears.
module hist_builder_mp
   import hist_builder_mp_pkg::*;
#(
   parameter int NP         = NP_DEF,
   parameter int NB         = NB_DEF,
   parameter int PIXELS     = PIXELS_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int FINE_SHIFT = FINE_SHIFT_DEF,
   parameter int PIX_W      = $clog2(PIXELS)
) (
   input  logic             clk,
   input  logic             res,
   input  logic             acq_start,
   input  logic             acq_stop,
   input  logic             mode,
   input  logic [NP-1:0]    fine_base,
   input  logic             wr_en,
   input  logic [PIX_W-1:0] pix_id,
   input  logic [NP-1:0]    data,
   output logic             busy,
   output logic             peak_valid,
   input  logic             peak_ready,
   output logic [PIX_W-1:0] peak_pix,
   output logic [NP-1:0]    peak_bin,
   output logic [CNT_W-1:0] peak_cnt,
   output logic [15:0]      drop_cnt,
   output logic             done
);

   // state | meaning
   // IDLE  | waiting for acq_start; bins and peaks already zero
   // ACQ   | timestamps enter the S0/S1 pipeline
   // DRAIN | one cycle so an event still in S0 lands in the bins
   // OUT   | one peak record per pixel over valid/ready
   // CLEAR | zero one bin index per cycle, clr_q counting down to 0

   localparam int NBINS = 2**NB;

   state_e           state_q, state_d;
   logic             mode_q, mode_d;
   logic [NP-1:0]    base_q, base_d;
   logic [15:0]      drop_q, drop_d;
   logic             s0_valid_q, s0_valid_d;
   logic [PIX_W-1:0] s0_pix_q, s0_pix_d;
   logic [NB-1:0]    s0_bin_q, s0_bin_d;
   logic [NP-1:0]    s0_abs_q, s0_abs_d;
   logic [CNT_W-1:0] bins_q [PIXELS][NBINS];
   logic [CNT_W-1:0] bins_d [PIXELS][NBINS];
   logic [CNT_W-1:0] pk_cnt_q [PIXELS];
   logic [CNT_W-1:0] pk_cnt_d [PIXELS];
   logic [NP-1:0]    pk_abs_q [PIXELS];
   logic [NP-1:0]    pk_abs_d [PIXELS];
   logic [PIX_W-1:0] out_idx_q, out_idx_d;
   logic [NB-1:0]    clr_q, clr_d;
   logic             done_q, done_d;

   logic [NB-1:0]    map_bin;
   logic             map_in_range;
   logic [NP-1:0]    map_abs;
   logic             pix_ok;
   logic             out_last;
   logic [CNT_W-1:0] cur_cnt;
   logic [CNT_W-1:0] nxt_cnt;

   hist_builder_mp_bin_map #(
      .NP         (NP),
      .NB         (NB),
      .FINE_SHIFT (FINE_SHIFT)
   ) u_bin_map (
      .data      (data),
      .mode      (mode_q),
      .fine_base (base_q),
      .bin       (map_bin),
      .in_range  (map_in_range),
      .bin_abs   (map_abs)
   );

   assign pix_ok   = (32'(pix_id) < PIXELS);
   assign out_last = (out_idx_q == PIX_W'(PIXELS - 1));

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      base_d     = base_q;
      drop_d     = drop_q;
      s0_valid_d = 1'b0;
      s0_pix_d   = s0_pix_q;
      s0_bin_d   = s0_bin_q;
      s0_abs_d   = s0_abs_q;
      bins_d     = bins_q;
      pk_cnt_d   = pk_cnt_q;
      pk_abs_d   = pk_abs_q;
      out_idx_d  = out_idx_q;
      clr_d      = clr_q;
      done_d     = 1'b0;
      cur_cnt    = bins_q[s0_pix_q][s0_bin_q];
      nxt_cnt    = cur_cnt + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (acq_start) begin
               state_d = ST_ACQ;
               mode_d  = mode;
               base_d  = fine_base;
               drop_d  = '0;
            end
         end
         ST_ACQ: begin
            if (acq_stop) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            state_d   = ST_OUT;
            out_idx_d = '0;
         end
         ST_OUT: begin
            if (peak_ready) begin
               if (out_last) begin
                  state_d = ST_CLEAR;
                  clr_d   = '1;
               end else begin
                  out_idx_d = out_idx_q + PIX_W'(1);
               end
            end
         end
         ST_CLEAR: begin
            for (int p = 0; p < PIXELS; p++) begin
               bins_d[p][clr_q] = '0;
               pk_cnt_d[p]      = '0;
               pk_abs_d[p]      = '0;
            end
            if (clr_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               clr_d = clr_q - NB'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q == ST_ACQ && wr_en) begin
         if (map_in_range && pix_ok) begin
            s0_valid_d = 1'b1;
            s0_pix_d   = pix_id;
            s0_bin_d   = map_bin;
            s0_abs_d   = map_abs;
         end else begin
            drop_d = sat_inc16(drop_q);
         end
      end

      // S1 read-modify-write; a saturated bin neither changes nor moves the peak
      if (s0_valid_q && cur_cnt != '1) begin
         bins_d[s0_pix_q][s0_bin_q] = nxt_cnt;
         if (nxt_cnt > pk_cnt_q[s0_pix_q]) begin
            pk_cnt_d[s0_pix_q] = nxt_cnt;
            pk_abs_d[s0_pix_q] = s0_abs_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_COARSE;
         base_q     <= '0;
         drop_q     <= '0;
         s0_valid_q <= 1'b0;
         s0_pix_q   <= '0;
         s0_bin_q   <= '0;
         s0_abs_q   <= '0;
         bins_q     <= '{default: '0};
         pk_cnt_q   <= '{default: '0};
         pk_abs_q   <= '{default: '0};
         out_idx_q  <= '0;
         clr_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         base_q     <= base_d;
         drop_q     <= drop_d;
         s0_valid_q <= s0_valid_d;
         s0_pix_q   <= s0_pix_d;
         s0_bin_q   <= s0_bin_d;
         s0_abs_q   <= s0_abs_d;
         bins_q     <= bins_d;
         pk_cnt_q   <= pk_cnt_d;
         pk_abs_q   <= pk_abs_d;
         out_idx_q  <= out_idx_d;
         clr_q      <= clr_d;
         done_q     <= done_d;
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign peak_valid = (state_q == ST_OUT);
   assign peak_pix   = peak_valid ? out_idx_q : '0;
   assign peak_cnt   = peak_valid ? pk_cnt_q[out_idx_q] : '0;
   assign peak_bin   = peak_valid ? pk_abs_q[out_idx_q] : '0;
   assign drop_cnt   = drop_q;
   assign done       = done_q;

endmodule

// File: tb/tb_hist_builder_mp.sv
// Bench for hist_builder_mp: directed scenarios plus randomized acquisitions,
// checked against a per-bin count/time reference model.
module tb_hist_builder_mp;

   logic       clk = 1'b0;
   logic       res, acq_start, acq_stop, mode, wr_en, peak_ready;
   logic [9:0] fine_base, data;
   logic [1:0] pix_id;
   logic       busy, peak_valid, done;
   logic [1:0] peak_pix;
   logic [9:0] peak_bin;
   logic [7:0] peak_cnt;
   logic [15:0] drop_cnt;

   int n_total = 0;
   int n_pass  = 0;

   // reference model: count per bin and the event index at which it last grew
   int m_cnt  [3][16];
   int m_when [3][16];
   int m_ev, m_drop, m_base;
   bit m_mode, m_acq;

   always #5 clk = ~clk;

   hist_builder_mp #(
      .NP(10), .NB(4), .PIXELS(3), .CNT_W(8), .FINE_SHIFT(2)
   ) dut (
      .clk        (clk),
      .res        (res),
      .acq_start  (acq_start),
      .acq_stop   (acq_stop),
      .mode       (mode),
      .fine_base  (fine_base),
      .wr_en      (wr_en),
      .pix_id     (pix_id),
      .data       (data),
      .busy       (busy),
      .peak_valid (peak_valid),
      .peak_ready (peak_ready),
      .peak_pix   (peak_pix),
      .peak_bin   (peak_bin),
      .peak_cnt   (peak_cnt),
      .drop_cnt   (drop_cnt),
      .done       (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_clear();
      for (int p = 0; p < 3; p++)
         for (int b = 0; b < 16; b++) begin
            m_cnt[p][b]  = 0;
            m_when[p][b] = 0;
         end
      m_ev   = 0;
      m_drop = 0;
   endtask

   task automatic model_hit(input int p, input int d);
      int b;
      if (!m_acq) return;
      if (p >= 3) begin
         if (m_drop < 65535) m_drop++;
         return;
      end
      if (!m_mode) b = d / 64;
      else begin
         if (d < m_base || (d - m_base) / 4 >= 16) begin
            if (m_drop < 65535) m_drop++;
            return;
         end
         b = (d - m_base) / 4;
      end
      if (m_cnt[p][b] < 255) begin
         m_cnt[p][b]++;
         m_when[p][b] = m_ev;
      end
      m_ev++;
   endtask

   // highest count wins; among equal counts the bin that got there first
   function automatic void exp_rec(input int p, output int c, output int bin);
      int best = 0, bw = 0, bb = 0;
      for (int b = 0; b < 16; b++)
         if (m_cnt[p][b] > best || (m_cnt[p][b] == best && best > 0 && m_when[p][b] < bw)) begin
            best = m_cnt[p][b];
            bw   = m_when[p][b];
            bb   = b;
         end
      c = best;
      if (best == 0) bin = 0;
      else if (m_mode) bin = (m_base + bb * 4) % 1024;
      else bin = bb * 64;
   endfunction

   task automatic start_acq(input bit m, input int base);
      mode      = m;
      fine_base = 10'(base);
      acq_start = 1'b1;
      tick();
      acq_start = 1'b0;
      if (!m_acq) begin
         m_acq  = 1'b1;
         m_mode = m;
         m_base = base;
         model_clear();
      end
   endtask

   task automatic hit(input int p, input int d);
      wr_en  = 1'b1;
      pix_id = 2'(p);
      data   = 10'(d);
      model_hit(p, d);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic stop_acq();
      acq_stop = 1'b1;
      tick();
      acq_stop = 1'b0;
      m_acq    = 1'b0;
   endtask

   task automatic stop_with_hit(input int p, input int d);
      wr_en    = 1'b1;
      pix_id   = 2'(p);
      data     = 10'(d);
      acq_stop = 1'b1;
      model_hit(p, d);
      tick();
      wr_en    = 1'b0;
      acq_stop = 1'b0;
      m_acq    = 1'b0;
   endtask

   // call right after the acq_stop edge; reads all records, then waits for done
   task automatic collect(input int hold, input bit rnd);
      int  w = 0, cyc = 0, idx = 0, ec, eb;
      bit  rdy;
      chk("drain_busy", busy, 1);
      while (!peak_valid && w < 8) begin
         tick();
         w++;
      end
      chk("drain_len", w, 1);
      chk("drop_cnt", drop_cnt, m_drop);
      while (idx < 3 && cyc < 200) begin
         chk("valid", peak_valid, 1);
         if (!peak_valid) break;
         exp_rec(idx, ec, eb);
         chk("peak_pix", peak_pix, idx);
         chk("peak_cnt", peak_cnt, ec);
         chk("peak_bin", peak_bin, eb);
         rdy = (cyc >= hold) && (!rnd || $urandom_range(0, 1) == 1);
         peak_ready = rdy;
         tick();
         cyc++;
         if (rdy) idx++;
      end
      peak_ready = 1'b0;
      chk("records", idx, 3);
      if (!rnd) chk("out_cycles", cyc, hold + 3);
      chk("valid_after_out", peak_valid, 0);
      cyc = 0;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("clear_len", cyc, 16);
      chk("busy_at_done", busy, 0);
      tick();
      chk("done_pulse", done, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int n, m, base, p, d;
      res = 1'b1; acq_start = 1'b0; acq_stop = 1'b0; mode = 1'b0;
      fine_base = '0; wr_en = 1'b0; pix_id = '0; data = '0; peak_ready = 1'b0;
      m_acq = 1'b0; m_mode = 1'b0; m_base = 0;
      model_clear();
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_valid", peak_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_cnt", peak_cnt, 0);
      chk("rst_bin", peak_bin, 0);
      chk("rst_pix", peak_pix, 0);
      res = 1'b0;
      tick();

      // coarse with ignored controls; last hit lands on the acq_stop cycle
      acq_stop = 1'b1;
      tick();
      acq_stop = 1'b0;
      chk("stop_in_idle", busy, 0);
      hit(0, 5);
      chk("wr_in_idle", busy, 0);
      start_acq(0, 0);
      chk("acq_busy", busy, 1);
      hit(0, 108);
      mode = 1'b1; fine_base = 10'd900; acq_start = 1'b1;
      tick();
      acq_start = 1'b0;
      hit(0, 511);
      hit(0, 511);
      stop_with_hit(1, 1023);
      collect(0, 0);

      // fine window at 64, one hit beyond the window
      start_acq(1, 64);
      hit(0, 90); hit(0, 90); hit(0, 91); hit(0, 200);
      stop_acq();
      collect(0, 0);

      // saturation, back-to-back hits into one bin; drop_cnt cleared by start
      start_acq(0, 0);
      chk("drop_cleared", drop_cnt, 0);
      for (int i = 0; i < 300; i++) hit(2, 300);
      stop_acq();
      collect(0, 0);

      // ties keep the earlier bin, a further hit moves the peak
      start_acq(0, 0);
      hit(0, 200); hit(0, 210); hit(0, 600); hit(0, 620);
      stop_acq();
      collect(0, 0);
      start_acq(0, 0);
      hit(0, 200); hit(0, 210); hit(0, 600); hit(0, 620); hit(0, 590);
      stop_acq();
      collect(0, 0);

      // backpressure on the first record
      start_acq(0, 0);
      hit(0, 700); hit(1, 30); hit(1, 31); hit(2, 1000); hit(3, 10);
      stop_acq();
      collect(5, 0);

      // reset mid-acquisition, then an empty acquisition
      start_acq(0, 0);
      hit(0, 100); hit(1, 200); hit(3, 300); hit(2, 400);
      res = 1'b1;
      tick();
      res = 1'b0;
      m_acq = 1'b0;
      model_clear();
      chk("res_busy", busy, 0);
      chk("res_drop", drop_cnt, 0);
      chk("res_valid", peak_valid, 0);
      tick();
      start_acq(0, 0);
      stop_acq();
      collect(0, 0);

      // randomized acquisitions
      for (int k = 0; k < 8; k++) begin
         m    = $urandom_range(0, 1);
         base = $urandom_range(0, 1023);
         start_acq(m[0], base);
         n = $urandom_range(20, 60);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            else begin
               p = $urandom_range(0, 3);
               if (m == 1) d = (base + $urandom_range(0, 90)) % 1024;
               else if (k % 2 == 0) d = $urandom_range(0, 3) * 64 + $urandom_range(0, 63);
               else d = $urandom_range(0, 1023);
               hit(p, d);
            end
         end
         stop_with_hit($urandom_range(0, 2), $urandom_range(0, 1023));
         collect($urandom_range(0, 3), 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
